unsigned_16by8_seq_div: RTL and testbench



---
 rtl/unsigned_16by8_seq_div_pkg.sv | 17 +
 rtl/unsigned_16by8_seq_div_if.sv | 24 ++
 rtl/unsigned_16by8_seq_div_step_restoring.sv | 20 ++
 rtl/unsigned_16by8_seq_div.sv | 133 +++++++++++++
 tb/tb_unsigned_16by8_seq_div.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unsigned_16by8_seq_div_pkg.sv
// Shared constants and types for the sequential 16/8 unsigned divider.
// Widths match the 8x8 multiplier family: 8-bit operands, 16-bit products.
package unsigned_16by8_seq_div_pkg;

    localparam int X_W = 8;
    localparam int Z_W = 16;

    // All-ones quotient reported when the divisor is zero.
    localparam logic [Z_W-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/unsigned_16by8_seq_div_if.sv
// Valid/ready operand and result streams of the sequential divider.
interface unsigned_16by8_seq_div_if;

    logic                                       in_valid;
    logic                                       in_ready;
    logic [unsigned_16by8_seq_div_pkg::Z_W-1:0] z;
    logic [unsigned_16by8_seq_div_pkg::X_W-1:0] y;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [unsigned_16by8_seq_div_pkg::Z_W-1:0] q;
    logic [unsigned_16by8_seq_div_pkg::X_W-1:0] r;
    logic                                       div_by_zero;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, q, r, div_by_zero
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, q, r, div_by_zero
    );

endinterface

// File: rtl/unsigned_16by8_seq_div_step_restoring.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not underflow.
module unsigned_16by8_seq_div_step_restoring
    import unsigned_16by8_seq_div_pkg::*;
(
    input  logic [X_W-1:0] p,
    input  logic           d_bit,
    input  logic [X_W-1:0] y,
    output logic [X_W-1:0] p_next,
    output logic           q_bit
);

    // The trial value needs the ninth bit; the kept remainder is always < y.
    logic [X_W:0] t;

    assign t      = {p, d_bit};
    assign q_bit  = (t >= {1'b0, y});
    assign p_next = q_bit ? (t[X_W-1:0] - y) : t[X_W-1:0];

endmodule

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential restoring divider q = ((z >> TRUNC) / y) << TRUNC, r = (z >> TRUNC) % y.
// TRUNC (legal 0..8) drops dividend LSBs and their iterations for lower latency.
module unsigned_16by8_seq_div
    import unsigned_16by8_seq_div_pkg::*;
#(
    parameter int TRUNC = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    unsigned_16by8_seq_div_if.slave bus
);

    localparam int             ITER     = Z_W - TRUNC;
    localparam logic [4:0]     CNT_INIT = 5'(ITER - 1);

    state_t          state;
    state_t          state_next;
    logic            in_ready_c;

    logic [ITER-1:0] d;
    logic [ITER-1:0] quo;
    logic [X_W-1:0]  p;
    logic [X_W-1:0]  y_q;
    logic [4:0]      cnt;
    logic            zero_div;

    logic            out_valid_q;
    logic [Z_W-1:0]  q_q;
    logic [X_W-1:0]  r_q;
    logic            dz_q;

    logic [X_W-1:0]  p_step;
    logic            q_bit;
    logic [Z_W-1:0]  q_exact;
    logic            accept;
    logic            drain;
    logic            load_result;

    unsigned_16by8_seq_div_step_restoring u_step (
        .p      (p),
        .d_bit  (d[ITER-1]),
        .y      (y_q),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    assign accept      = (state == IDLE) && bus.in_valid;
    assign drain       = out_valid_q && bus.out_ready;
    // Results are registered on the first DONE cycle, so out_valid trails DONE by one edge.
    assign load_result = (state == DONE) && !out_valid_q;
    assign q_exact     = Z_W'(quo) << TRUNC;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = (bus.y == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (drain) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the datapath is small and fully reset, so an abort leaves no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d           <= '0;
            quo         <= '0;
            p           <= '0;
            y_q         <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
        end else begin
            if (accept) begin
                d        <= bus.z[Z_W-1:TRUNC];
                quo      <= '0;
                // A zero divisor reports the low dividend byte as its remainder.
                p        <= (bus.y == '0) ? bus.z[X_W-1:0] : '0;
                y_q      <= bus.y;
                cnt      <= CNT_INIT;
                zero_div <= (bus.y == '0);
            end else if (state == BUSY) begin
                d   <= d << 1;
                p   <= p_step;
                quo <= {quo[ITER-2:0], q_bit};
                cnt <= cnt - 5'd1;
            end

            if (load_result) begin
                out_valid_q <= 1'b1;
                q_q         <= zero_div ? DIV_ZERO_Q : q_exact;
                r_q         <= p;
                dz_q        <= zero_div;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Scoreboard bench: an exact build (TRUNC=0) and a truncated build (TRUNC=4)
// are driven side by side and compared against plain-arithmetic expectations.
module tb_unsigned_16by8_seq_div;
    import unsigned_16by8_seq_div_pkg::*;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;

    logic        in_valid_v  [2];
    logic        out_ready_v [2];
    logic [15:0] z_v         [2];
    logic [7:0]  y_v         [2];
    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic [15:0] q_v         [2];
    logic [7:0]  r_v         [2];
    logic        dz_v        [2];

    exp_t exp_q [2][$];

    unsigned_16by8_seq_div_if bus0 ();
    unsigned_16by8_seq_div_if bus1 ();

    assign bus0.in_valid  = in_valid_v[0];
    assign bus0.z         = z_v[0];
    assign bus0.y         = y_v[0];
    assign bus0.out_ready = out_ready_v[0];
    assign in_ready_v[0]  = bus0.in_ready;
    assign out_valid_v[0] = bus0.out_valid;
    assign q_v[0]         = bus0.q;
    assign r_v[0]         = bus0.r;
    assign dz_v[0]        = bus0.div_by_zero;

    assign bus1.in_valid  = in_valid_v[1];
    assign bus1.z         = z_v[1];
    assign bus1.y         = y_v[1];
    assign bus1.out_ready = out_ready_v[1];
    assign in_ready_v[1]  = bus1.in_ready;
    assign out_valid_v[1] = bus1.out_valid;
    assign q_v[1]         = bus1.q;
    assign r_v[1]         = bus1.r;
    assign dz_v[1]        = bus1.div_by_zero;

    unsigned_16by8_seq_div #(.TRUNC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    unsigned_16by8_seq_div #(.TRUNC(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Instance g is built with TRUNC = 4*g.
    function automatic exp_t model(input int g, input logic [15:0] zz, input logic [7:0] yy);
        exp_t e;
        int   t;
        int   zd;
        t  = 4 * g;
        zd = int'(zz) >> t;
        e.acc = 0;
        if (yy == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = zz[7:0];
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = 16'((zd / int'(yy)) << t);
            e.r   = 8'(zd % int'(yy));
            e.dz  = 1'b0;
            e.lat = 16 - t + 1;
        end
        return e;
    endfunction

    task automatic issue(input int g, input logic [15:0] zz, input logic [7:0] yy);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid_v[g] = 1'b1;
        z_v[g]        = zz;
        y_v[g]        = yy;
        while (!in_ready_v[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[g]) begin
            fail($sformatf("accept_timeout[%0d]", g));
            in_valid_v[g] = 1'b0;
        end else begin
            e     = model(g, zz, yy);
            e.acc = cyc + 1;
            exp_q[g].push_back(e);
            @(negedge clk);
            in_valid_v[g] = 1'b0;
            z_v[g]        = 16'($urandom);
            y_v[g]        = 8'($urandom);
        end
    endtask

    task automatic drain(input int g);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || out_valid_v[g]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_pending[%0d]", g), 32'(exp_q[g].size()), 32'd0);
    endtask

    task automatic rand_run(input int g, input int count);
        logic [15:0] zz;
        logic [7:0]  yy;
        for (int i = 0; i < count; i++) begin
            zz = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            yy = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            issue(g, zz, yy);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic        prev_v  = 1'b0;
        logic        prev_hs = 1'b0;
        int          rise    = 0;
        logic [15:0] hq;
        logic [7:0]  hr;
        logic        hdz;

        always @(posedge clk) begin
            if (rand_bp) begin
                #2;
                out_ready_v[g] = 1'($urandom_range(0, 1));
            end
        end

        always @(negedge clk) begin
            int   rise_now;
            exp_t e;
            if (!rst_n) begin
                prev_v  <= 1'b0;
                prev_hs <= 1'b0;
            end else begin
                if (prev_hs) begin
                    check($sformatf("drop_out_valid[%0d]", g), 32'(out_valid_v[g]), 32'd0);
                    check($sformatf("rise_in_ready[%0d]", g), 32'(in_ready_v[g]), 32'd1);
                end
                if (out_valid_v[g]) begin
                    rise_now = prev_v ? rise : cyc;
                    if (!prev_v && exp_q[g].size() == 0) begin
                        fail($sformatf("unexpected_out_valid[%0d]", g));
                    end
                    if (prev_v) begin
                        check($sformatf("hold_q[%0d]", g), 32'(q_v[g]), 32'(hq));
                        check($sformatf("hold_r[%0d]", g), 32'(r_v[g]), 32'(hr));
                        check($sformatf("hold_dz[%0d]", g), 32'(dz_v[g]), 32'(hdz));
                    end
                    check($sformatf("busy_in_ready[%0d]", g), 32'(in_ready_v[g]), 32'd0);
                    if (out_ready_v[g] && exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check($sformatf("q[%0d]", g), 32'(q_v[g]), 32'(e.q));
                        check($sformatf("r[%0d]", g), 32'(r_v[g]), 32'(e.r));
                        check($sformatf("div_by_zero[%0d]", g), 32'(dz_v[g]), 32'(e.dz));
                        check($sformatf("latency[%0d]", g), 32'(rise_now - e.acc), 32'(e.lat));
                    end
                    rise <= rise_now;
                end
                prev_v  <= out_valid_v[g];
                prev_hs <= out_valid_v[g] && out_ready_v[g];
                hq      <= q_v[g];
                hr      <= r_v[g];
                hdz     <= dz_v[g];
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid_v[g]  = 1'b0;
            out_ready_v[g] = 1'b1;
            z_v[g]         = '0;
            y_v[g]         = '0;
        end
        #12;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_in_ready[%0d]", g), 32'(in_ready_v[g]), 32'd1);
            check($sformatf("reset_out_valid[%0d]", g), 32'(out_valid_v[g]), 32'd0);
            check($sformatf("reset_q[%0d]", g), 32'(q_v[g]), 32'd0);
            check($sformatf("reset_r[%0d]", g), 32'(r_v[g]), 32'd0);
            check($sformatf("reset_dz[%0d]", g), 32'(dz_v[g]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Exact build: directed corners, including divide-by-zero and z==0.
        issue(0, 16'd1000, 8'd7);
        issue(0, 16'd65535, 8'd1);
        issue(0, 16'd65535, 8'd255);
        issue(0, 16'd5, 8'd200);
        issue(0, 16'd0, 8'd13);
        issue(0, 16'h1234, 8'd0);
        issue(0, 16'd10, 8'd3);
        drain(0);

        // Truncated build.
        issue(1, 16'd1000, 8'd7);
        issue(1, 16'h1234, 8'd0);
        drain(1);

        // Result held under backpressure, then released.
        out_ready_v[0] = 1'b0;
        issue(0, 16'd1000, 8'd7);
        n = 0;
        while (!out_valid_v[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_v[0]) fail("backpressure_wait");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 out_ready_v[0] = 1'b1;
        drain(0);

        // Asynchronous reset in the middle of a division.
        issue(0, 16'd1000, 8'd7);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("midrst_q", 32'(q_v[0]), 32'd0);
        check("midrst_r", 32'(r_v[0]), 32'd0);
        check("midrst_dz", 32'(dz_v[0]), 32'd0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(0, 16'd100, 8'd9);
        drain(0);

        // Random operands with random backpressure on both builds at once.
        rand_bp = 1'b1;
        fork
            rand_run(0, 800);
            rand_run(1, 800);
        join
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready_v[0] = 1'b1;
        out_ready_v[1] = 1'b1;
        drain(0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
